// File: rtl/fifo_buffer_ctrl.sv
// fifo_buffer_ctrl: single-clock FIFO with occupancy count, status flags,
// runtime almost-full/almost-empty thresholds and sticky overflow/underflow.
// Read data is registered and qualified by data_out_valid.
// Reads happen before writes, so on a full FIFO a simultaneous push and pop
// returns the old word and stores the new one.
module fifo_buffer_ctrl #(
    parameter int WORD_SIZE = 6,
    parameter int DEPTH     = 8,
    parameter int PTR_L     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PTR_L:0]       afull_thr,
    input  logic [PTR_L:0]       aempty_thr,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_out_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_L:0]       count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [PTR_L:0] DEPTH_C = (PTR_L + 1)'(DEPTH);

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_L-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_L-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_L:0]       count_q, count_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 push_ok, pop_ok;

    // Status flags come straight from the registered count and live thresholds.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= afull_thr);
    assign almost_empty = (count_q <= aempty_thr);

    assign count          = count_q;
    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    // Acceptance, pointer/count next-state, read data and error flag updates.
    always_comb begin
        pop_ok      = pop & ~empty;
        push_ok     = push & (~full | pop_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = '0;
        valid_d     = 1'b0;
        overflow_d  = overflow_q | (push & ~push_ok);
        underflow_d = underflow_q | (pop & ~pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wipes storage too so nothing stale survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_in;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_buffer_ctrl.sv
// Testbench for fifo_buffer_ctrl: stimulus pushes per-cycle expected read
// responses into a queue; a monitor pops and compares them independently.
module tb_fifo_buffer_ctrl;

    localparam int W = 6;
    localparam int D = 8;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         push, pop;
    logic [P:0]   afull_thr, aempty_thr;
    logic [W-1:0] data_out;
    logic         data_out_valid, full, empty, almost_full, almost_empty;
    logic [P:0]   count;
    logic         overflow, underflow;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mq[$];
    logic         m_ov, m_un;
    int           n_checks = 0;
    int           n_pass   = 0;

    fifo_buffer_ctrl #(.WORD_SIZE(W), .DEPTH(D), .PTR_L(P)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .data_out(data_out),
        .data_out_valid(data_out_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Read-side monitor: one expected response per stepped cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid", 32'(data_out_valid), 32'(e.v));
                if (e.v) chk("rd_data", 32'(data_out), 32'(e.d));
                else if (data_out !== '0) chk("rd_idle_data", 32'(data_out), 32'd0);
            end
        end
    end

    // One clock of stimulus, with the behavioural queue model updated alongside.
    task automatic step(input logic rst, input logic ps, input logic pp, input logic [W-1:0] din);
        exp_t   e;
        logic   pop_ok, push_ok;
        int     af, ae;
        @(negedge clk);
        reset = rst; push = ps; pop = pp; data_in = din;
        @(posedge clk);
        #1;
        e = '0;
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            pop_ok  = pp && (mq.size() > 0);
            push_ok = ps && ((mq.size() < D) || pop_ok);
            if (pop_ok) begin
                e.v = 1'b1;
                e.d = mq.pop_front();
            end
            if (push_ok) mq.push_back(din);
            if (ps && !push_ok) m_ov = 1'b1;
            if (pp && !pop_ok)  m_un = 1'b1;
        end
        exp_q.push_back(e);
        af = (mq.size() >= int'(afull_thr)) ? 1 : 0;
        ae = (mq.size() <= int'(aempty_thr)) ? 1 : 0;
        chk("status", {count, full, empty, almost_full, almost_empty, overflow, underflow},
            {4'(mq.size()), (mq.size() == D), (mq.size() == 0), 1'(af), 1'(ae), m_ov, m_un});
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        afull_thr = 4'd6; aempty_thr = 4'd2;
        m_ov = 1'b0; m_un = 1'b0;

        // Reset held two cycles with push and pop asserted.
        step(1, 1, 1, 6'h15);
        step(1, 1, 1, 6'h16);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_valid", 32'(data_out_valid), 0);
        chk("rst_flags", {overflow, underflow}, 0);

        // Fill 0x01..0x08.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 6'(i));
        chk("fill_count", 32'(count), 8);
        chk("fill_full", 32'(full), 1);

        // Full with simultaneous push and pop: accepted, no overflow.
        step(0, 1, 1, 6'h09);
        chk("full_pp_count", 32'(count), 8);
        chk("full_pp_ovf", 32'(overflow), 0);

        // Overflow: push into full FIFO without pop; data dropped.
        step(0, 1, 0, 6'h3F);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);

        // Drain: expect 0x02..0x09, never 0x3F.
        for (int i = 0; i < 8; i++) step(0, 0, 1, '0);
        chk("drain_empty", 32'(empty), 1);

        // Underflow.
        step(0, 0, 1, '0);
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_valid", 32'(data_out_valid), 0);

        // Pop on empty with a push in the same cycle: no bypass.
        step(0, 1, 1, 6'h2C);
        chk("nobypass_valid", 32'(data_out_valid), 0);
        chk("nobypass_count", 32'(count), 1);

        // Clear, then streaming at count 3 for 10 cycles across the wrap.
        step(1, 0, 0, '0);
        chk("rst_clears_flags", {overflow, underflow}, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 6'(6'h10 + i));
        for (int i = 0; i < 10; i++) step(0, 1, 1, 6'(6'h13 + i));
        chk("stream_count", 32'(count), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0);

        // Thresholds: af=6, ae=2.
        step(1, 0, 0, '0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 0, 6'(6'h20 + i));
            if (i == 2) chk("ae_at2", 32'(almost_empty), 1);
            if (i == 3) chk("ae_at3", 32'(almost_empty), 0);
            if (i == 5) chk("af_at5", 32'(almost_full), 0);
            if (i == 6) chk("af_at6", 32'(almost_full), 1);
        end
        step(0, 0, 1, '0);
        chk("pre_mid_rst_count", 32'(count), 5);

        // Mid-operation reset with concurrent pop.
        step(1, 0, 1, '0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(data_out_valid), 0);
        step(0, 1, 0, 6'h31);
        step(0, 1, 0, 6'h32);
        step(0, 0, 1, '0);
        chk("post_rst_first", 32'(data_out), 32'h31);
        step(0, 0, 1, '0);

        // Zero almost-full threshold is always asserted.
        afull_thr = 4'd0;
        step(0, 0, 0, '0);
        chk("af_thr0", 32'(almost_full), 1);

        // Let the monitor consume what remains, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
